// File: rtl/dcache_pkg.sv
// Shared dcache definitions: default geometry, derived widths, flush FSM states
// and the line base-address builder.
package dcache_pkg;

    localparam int unsigned DC_SETS       = 64;
    localparam int unsigned DC_WAYS       = 4;
    localparam int unsigned DC_LINE_BYTES = 64;
    localparam int unsigned DC_PADDR      = 56;

    localparam int unsigned DC_SW = $clog2(DC_SETS);
    localparam int unsigned DC_WW = $clog2(DC_WAYS);
    localparam int unsigned DC_OW = $clog2(DC_LINE_BYTES);
    localparam int unsigned DC_TW = DC_PADDR - DC_SW - DC_OW;

    // Widest physical address the address builder handles.
    localparam int unsigned ADDR_MAX = 64;

    typedef enum logic [2:0] {
        FL_IDLE,
        FL_LOCK,
        FL_RD,
        FL_CHK,
        FL_WB,
        FL_WWAIT,
        FL_INV,
        FL_DONE
    } flush_state_e;

    // Line base address {tag, set, zero offset}; caller truncates to PADDR.
    function automatic logic [ADDR_MAX-1:0] line_addr(
        input logic [ADDR_MAX-1:0] tag,
        input logic [ADDR_MAX-1:0] set,
        input int unsigned         sw,
        input int unsigned         ow
    );
        return (tag << (sw + ow)) | (set << ow);
    endfunction

endpackage

// File: rtl/dcache_flush_unit.sv
// Dcache flush responder: locks the pipeline, walks every set/way, writes back
// dirty lines, invalidates every line, then pulses a single-cycle ack.
module dcache_flush_unit
    import dcache_pkg::*;
#(
    parameter int unsigned SETS       = dcache_pkg::DC_SETS,
    parameter int unsigned WAYS       = dcache_pkg::DC_WAYS,
    parameter int unsigned LINE_BYTES = dcache_pkg::DC_LINE_BYTES,
    parameter int unsigned PADDR      = dcache_pkg::DC_PADDR,
    localparam int unsigned SW = $clog2(SETS),
    localparam int unsigned WW = $clog2(WAYS),
    localparam int unsigned OW = $clog2(LINE_BYTES),
    localparam int unsigned TW = PADDR - SW - OW
) (
    input  logic             clk_i,
    input  logic             arst_i,
    input  logic             flush_req_i,
    output logic             flush_ack_o,
    output logic             cache_lock_o,
    input  logic             lock_grant_i,
    output logic             tag_rd_en_o,
    output logic [SW-1:0]    tag_set_o,
    output logic [WW-1:0]    tag_way_o,
    input  logic             tag_valid_i,
    input  logic             tag_dirty_i,
    input  logic [TW-1:0]    tag_i,
    output logic             wb_req_valid_o,
    input  logic             wb_req_ready_i,
    output logic [PADDR-1:0] wb_req_addr_o,
    input  logic             wb_done_i,
    output logic             inv_en_o
);

    flush_state_e     state_q, state_d;
    logic [SW-1:0]    set_q, set_d;
    logic [WW-1:0]    way_q, way_d;
    logic [PADDR-1:0] addr_q, addr_d;
    logic             last_line;

    assign last_line = (set_q == SW'(SETS - 1)) && (way_q == WW'(WAYS - 1));

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= FL_IDLE;
            set_q   <= '0;
            way_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            set_q   <= set_d;
            way_q   <= way_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        set_d          = set_q;
        way_d          = way_q;
        addr_d         = addr_q;
        flush_ack_o    = 1'b0;
        cache_lock_o   = (state_q != FL_IDLE);
        tag_rd_en_o    = 1'b0;
        wb_req_valid_o = 1'b0;
        inv_en_o       = 1'b0;

        unique case (state_q)
            FL_IDLE: begin
                if (flush_req_i) state_d = FL_LOCK;
            end
            FL_LOCK: begin
                if (lock_grant_i) state_d = FL_RD;
            end
            FL_RD: begin
                tag_rd_en_o = 1'b1;
                state_d     = FL_CHK;
            end
            FL_CHK: begin
                // Tag array answers exactly one cycle after the read strobe.
                if (tag_valid_i && tag_dirty_i) begin
                    addr_d  = PADDR'(line_addr(ADDR_MAX'(tag_i), ADDR_MAX'(set_q), SW, OW));
                    state_d = FL_WB;
                end else begin
                    state_d = FL_INV;
                end
            end
            FL_WB: begin
                wb_req_valid_o = 1'b1;
                if (wb_req_ready_i) state_d = FL_WWAIT;
            end
            FL_WWAIT: begin
                if (wb_done_i) state_d = FL_INV;
            end
            FL_INV: begin
                inv_en_o = 1'b1;
                if (last_line) begin
                    state_d = FL_DONE;
                end else begin
                    // Set-major walk: ways advance first, then the set.
                    if (way_q == WW'(WAYS - 1)) begin
                        way_d = '0;
                        set_d = set_q + SW'(1);
                    end else begin
                        way_d = way_q + WW'(1);
                    end
                    state_d = FL_RD;
                end
            end
            FL_DONE: begin
                flush_ack_o = 1'b1;
                set_d       = '0;
                way_d       = '0;
                state_d     = FL_IDLE;
            end
            default: state_d = FL_IDLE;
        endcase
    end

    assign tag_set_o     = set_q;
    assign tag_way_o     = way_q;
    assign wb_req_addr_o = addr_q;

endmodule

// File: tb/tb_dcache_flush_unit.sv
// Scoreboard bench for dcache_flush_unit with a behavioural cache/write-back
// responder and per-flush expectations derived from the walk rules.
module tb_dcache_flush_unit;

    localparam int SETS       = 4;
    localparam int WAYS       = 2;
    localparam int LINE_BYTES = 64;
    localparam int PADDR      = 56;
    localparam int SW         = 2;
    localparam int WW         = 1;
    localparam int OW         = 6;
    localparam int TW         = PADDR - SW - OW;
    localparam int N          = SETS * WAYS;

    logic             clk_i = 1'b0;
    logic             arst_i;
    logic             flush_req_i;
    logic             flush_ack_o;
    logic             cache_lock_o;
    logic             lock_grant_i;
    logic             tag_rd_en_o;
    logic [SW-1:0]    tag_set_o;
    logic [WW-1:0]    tag_way_o;
    logic             tag_valid_i;
    logic             tag_dirty_i;
    logic [TW-1:0]    tag_i;
    logic             wb_req_valid_o;
    logic             wb_req_ready_i;
    logic [PADDR-1:0] wb_req_addr_o;
    logic             wb_done_i;
    logic             inv_en_o;

    dcache_flush_unit #(
        .SETS(SETS), .WAYS(WAYS), .LINE_BYTES(LINE_BYTES), .PADDR(PADDR)
    ) dut (
        .clk_i(clk_i), .arst_i(arst_i),
        .flush_req_i(flush_req_i), .flush_ack_o(flush_ack_o),
        .cache_lock_o(cache_lock_o), .lock_grant_i(lock_grant_i),
        .tag_rd_en_o(tag_rd_en_o), .tag_set_o(tag_set_o), .tag_way_o(tag_way_o),
        .tag_valid_i(tag_valid_i), .tag_dirty_i(tag_dirty_i), .tag_i(tag_i),
        .wb_req_valid_o(wb_req_valid_o), .wb_req_ready_i(wb_req_ready_i),
        .wb_req_addr_o(wb_req_addr_o), .wb_done_i(wb_done_i), .inv_en_o(inv_en_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Cache contents and per-line write-back timing chosen by the stimulus.
    bit            m_valid [N];
    bit            m_dirty [N];
    logic [TW-1:0] m_tag   [N];
    int            rdly    [N];
    int            ddly    [N];
    int            grant_dly = 0;
    bit            spur_en   = 0;

    int               exp_inv [$];
    logic [PADDR-1:0] exp_wb  [$];
    int               exp_ack [$];
    int               lock_lo = 1;
    int               lock_hi = 0;

    int checks = 0;
    int failures = 0;
    int acks_seen = 0;
    int last_ack_cyc = 0;
    bit mon_en = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: unexpected event at cycle %0d", nm, cyc);
    endtask

    function automatic logic [PADDR-1:0] exp_addr(input int i);
        return PADDR'(m_tag[i]) * PADDR'(SETS * LINE_BYTES) + PADDR'(i / WAYS) * PADDR'(LINE_BYTES);
    endfunction

    function automatic int cur_idx();
        return int'(tag_set_o) * WAYS + int'(tag_way_o);
    endfunction

    // Responder: tag array with 1-cycle latency, lock grant, write-back buffer.
    initial begin
        bit rd_prev, in_wb, acc_prev, in_ww;
        int rd_idx, lock_cnt, wb_cnt, wb_idx, ww_cnt, ww_d;
        rd_prev = 0; in_wb = 0; acc_prev = 0; in_ww = 0;
        rd_idx = 0; lock_cnt = 0; wb_cnt = 0; wb_idx = 0; ww_cnt = 0; ww_d = 1;
        lock_grant_i = 0; tag_valid_i = 0; tag_dirty_i = 0; tag_i = '0;
        wb_req_ready_i = 0; wb_done_i = 0;
        forever begin
            @(posedge clk_i);
            #1;
            if (arst_i) begin
                rd_prev = 0; in_wb = 0; acc_prev = 0; in_ww = 0; lock_cnt = 0;
                lock_grant_i = 0; wb_req_ready_i = 0; wb_done_i = 0;
                continue;
            end
            if (cache_lock_o) lock_cnt++; else lock_cnt = 0;
            lock_grant_i = cache_lock_o && (lock_cnt > grant_dly);

            if (rd_prev) begin
                tag_valid_i = m_valid[rd_idx];
                tag_dirty_i = m_dirty[rd_idx];
                tag_i       = m_tag[rd_idx];
            end else begin
                tag_valid_i = 1'($urandom_range(0, 1));
                tag_dirty_i = 1'($urandom_range(0, 1));
                tag_i       = TW'({$urandom, $urandom});
            end
            rd_prev = tag_rd_en_o;
            rd_idx  = cur_idx();

            if (inv_en_o) begin
                m_valid[cur_idx()] = 0;
                m_dirty[cur_idx()] = 0;
            end

            wb_done_i = 0;
            if (acc_prev) begin
                in_ww  = 1;
                ww_cnt = 0;
            end
            if (in_ww) begin
                ww_cnt++;
                if (ww_cnt == ww_d) begin
                    wb_done_i = 1;
                    in_ww     = 0;
                end
            end
            if (wb_req_valid_o) begin
                if (!in_wb) begin
                    in_wb  = 1;
                    wb_cnt = 0;
                    wb_idx = cur_idx();
                end
                wb_req_ready_i = (wb_cnt >= rdly[wb_idx]);
                if (spur_en && wb_cnt == 1) wb_done_i = 1;
                wb_cnt++;
                acc_prev = wb_req_ready_i;
                if (wb_req_ready_i) ww_d = ddly[wb_idx];
            end else begin
                in_wb          = 0;
                acc_prev       = 0;
                wb_req_ready_i = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents an event.
    initial begin
        bit               wb_prev_stall;
        logic [PADDR-1:0] wb_prev_addr;
        wb_prev_stall = 0;
        wb_prev_addr  = '0;
        forever begin
            @(negedge clk_i);
            if (arst_i) begin
                exp_inv.delete();
                exp_wb.delete();
                exp_ack.delete();
                wb_prev_stall = 0;
            end else if (mon_en) begin
                chk("cache_lock", 64'(cache_lock_o), 64'(cyc >= lock_lo && cyc <= lock_hi));
                if (cache_lock_o && !lock_grant_i) chk("rd_before_grant", 64'(tag_rd_en_o), 64'd0);
                if (inv_en_o) begin
                    if (exp_inv.size() == 0) fail_now("inv_extra");
                    else chk("inv_line", 64'(cur_idx()), 64'(exp_inv.pop_front()));
                end
                if (wb_req_valid_o) begin
                    if (wb_prev_stall) chk("wb_addr_stable", 64'(wb_req_addr_o), 64'(wb_prev_addr));
                    if (wb_req_ready_i) begin
                        if (exp_wb.size() == 0) fail_now("wb_extra");
                        else chk("wb_addr", 64'(wb_req_addr_o), 64'(exp_wb.pop_front()));
                    end
                    wb_prev_stall = !wb_req_ready_i;
                    wb_prev_addr  = wb_req_addr_o;
                end else begin
                    wb_prev_stall = 0;
                end
                if (flush_ack_o) begin
                    acks_seen++;
                    last_ack_cyc = cyc;
                    if (exp_ack.size() == 0) fail_now("ack_extra");
                    else chk("ack_cycle", 64'(cyc), 64'(exp_ack.pop_front()));
                end
            end
        end
    end

    task automatic prep_random();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = ($urandom_range(0, 9) < 7);
            m_dirty[i] = ($urandom_range(0, 9) < 4);
            m_tag[i]   = TW'({$urandom, $urandom});
            rdly[i]    = $urandom_range(0, 4);
            ddly[i]    = $urandom_range(1, 4);
        end
    endtask

    task automatic prep_clean();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1;
            m_dirty[i] = 0;
            m_tag[i]   = TW'({$urandom, $urandom});
            rdly[i]    = 0;
            ddly[i]    = 1;
        end
    endtask

    // Issues a request in the current cycle and records what the walk must produce.
    task automatic issue(input int g, output int c0);
        int t;
        grant_dly   = g;
        c0          = cyc;
        flush_req_i = 1;
        t = c0 + 2 + g + 3 * N;
        for (int i = 0; i < N; i++) begin
            exp_inv.push_back(i);
            if (m_valid[i] && m_dirty[i]) begin
                exp_wb.push_back(exp_addr(i));
                t += rdly[i] + 1 + ddly[i];
            end
        end
        exp_ack.push_back(t);
        lock_lo = c0 + 1;
        lock_hi = t;
    endtask

    task automatic wait_ack(input int drop_line);
        int target, budget;
        target = acks_seen + 1;
        budget = 3000;
        while (acks_seen < target && budget > 0) begin
            @(posedge clk_i);
            #1;
            budget--;
            if (drop_line >= 0 && flush_req_i && tag_rd_en_o && cur_idx() == drop_line)
                flush_req_i = 0;
        end
        if (budget == 0) fail_now("ack_timeout");
        flush_req_i = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    initial begin
        int c0, base, b;
        arst_i      = 1;
        flush_req_i = 0;
        prep_clean();
        idle(2);
        chk("rst_ack", 64'(flush_ack_o), 64'd0);
        chk("rst_lock", 64'(cache_lock_o), 64'd0);
        chk("rst_rd", 64'(tag_rd_en_o), 64'd0);
        chk("rst_wb_valid", 64'(wb_req_valid_o), 64'd0);
        chk("rst_inv", 64'(inv_en_o), 64'd0);
        chk("rst_set_way", 64'({tag_set_o, tag_way_o}), 64'd0);
        arst_i = 0;
        idle(2);
        mon_en = 1;

        // All-clean walk, immediate grant.
        prep_clean();
        issue(0, c0);
        wait_ack(-1);
        chk("t1_latency", 64'(last_ack_cyc - c0), 64'd26);
        idle(3);

        // Single dirty line at s2w1 with a stalled buffer and a stray done pulse.
        prep_clean();
        m_valid[3] = 0; m_dirty[3] = 1;
        m_dirty[5] = 1; m_tag[5] = TW'(48'h123); rdly[5] = 5; ddly[5] = 4;
        spur_en = 1;
        issue(0, c0);
        wait_ack(-1);
        spur_en = 0;
        chk("t2_latency", 64'(last_ack_cyc - c0), 64'd36);
        idle(3);

        // Grant withheld for 10 cycles.
        prep_random();
        issue(10, c0);
        wait_ack(-1);
        idle(3);

        // Request dropped on line 3 of the walk.
        prep_random();
        base = acks_seen;
        issue(0, c0);
        wait_ack(3);
        idle(6);
        chk("t4_one_ack", 64'(acks_seen - base), 64'd1);

        // Reset while a write-back is pending on s0w1.
        prep_random();
        m_valid[0] = 1; m_dirty[0] = 0;
        for (int i = 1; i < N; i++) begin
            m_valid[i] = 1; m_dirty[i] = 1; rdly[i] = 8;
        end
        issue(0, c0);
        b = 0;
        while (!wb_req_valid_o && b < 200) begin
            idle(1);
            b++;
        end
        if (b == 200) fail_now("wb_timeout");
        #2;
        arst_i = 1;
        #1;
        chk("arst_ack", 64'(flush_ack_o), 64'd0);
        chk("arst_lock", 64'(cache_lock_o), 64'd0);
        chk("arst_wb_valid", 64'(wb_req_valid_o), 64'd0);
        chk("arst_wb_addr", 64'(wb_req_addr_o), 64'd0);
        chk("arst_set_way", 64'({tag_set_o, tag_way_o}), 64'd0);
        flush_req_i = 0;
        @(negedge clk_i);
        @(posedge clk_i);
        #1;
        arst_i  = 0;
        lock_lo = 1;
        lock_hi = 0;
        idle(2);
        prep_random();
        issue(0, c0);
        wait_ack(-1);
        idle(3);

        // Back-to-back requests.
        base = acks_seen;
        prep_random();
        issue(0, c0);
        wait_ack(-1);
        idle(3);
        prep_random();
        issue($urandom_range(0, 3), c0);
        wait_ack(-1);
        idle(8);
        chk("t6_two_acks", 64'(acks_seen - base), 64'd2);

        // Randomized walks.
        for (int k = 0; k < 5; k++) begin
            prep_random();
            spur_en = 1'($urandom_range(0, 1));
            issue($urandom_range(0, 4), c0);
            wait_ack(-1);
            idle($urandom_range(1, 4));
        end
        spur_en = 0;
        idle(4);

        chk("inv_left", 64'(exp_inv.size()), 64'd0);
        chk("wb_left", 64'(exp_wb.size()), 64'd0);
        chk("ack_left", 64'(exp_ack.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
